watch_time_counter: RTL and testbench
=====================================

// Module: watch_time_counter
// PURPOSE
//  Free-running calendar/clock core, one stage downstream of the watch set-mode block.
//  Loads the packed set time {year,month,day,hour,minute,second} when en_time pulses.
//  Advances the time by one second per internal 1 Hz tick, with full carry through to year.
//  Its year/month/day/hour/minute/second outputs feed the display and set-mode blocks.
// PARAMETERS
//  CLK_FREQ    50_000_000  clk cycles per second; prescaler terminal count = CLK_FREQ-1
//  RESET_YEAR  2024        year value after reset (12-bit)
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous reset, active-high
//  en_time    in   1   1-cycle load strobe from the set block
//  bin_time   in   52  {year[51:40],month[39:32],day[31:24],hour[23:16],minute[15:8],second[7:0]}
//  hold       in   1   1 = freeze prescaler and counters (set mode active)
//  year       out  12  current year, binary
//  month      out  8   1..12
//  day        out  8   1..max_date(month,year)
//  hour       out  8   0..23
//  minute     out  8   0..59
//  second     out  8   0..59
//  sec_pulse  out  1   1-cycle strobe, high in the cycle the time advances
// BEHAVIOUR
//  Reset (rst=1 at posedge clk):
//   - RESET_YEAR-01-01 00:00:00, sec_pulse=0, prescaler=0.
//   - Reset overrides en_time and hold.
//  Prescaler:
//   - Counts 0..CLK_FREQ-1 while hold=0. Terminal count -> tick, counter back to 0.
//   - hold=1 freezes the count. No tick is produced while held.
//  Priority per cycle: rst > en_time > hold > tick.
//  Load (en_time=1):
//   - Fields register bin_time; new values are visible the next cycle.
//   - Prescaler clears to 0, so the first advance comes exactly CLK_FREQ cycles after load.
//   - A tick in the load cycle is discarded. sec_pulse=0. Load is accepted even if hold=1.
//  Load sanitising (combinational, before register):
//   - month 0 or >12 -> 1.
//   - day 0 -> 1; day > max_date -> max_date (max_date uses the sanitised month and loaded year).
//   - hour>23 -> 0; minute>59 -> 0; second>59 -> 0.
//   - year 0 -> 1.
//  Advance (tick and no load): sec_pulse=1 for that cycle.
//   - second 59->0 carries to minute.
//   - minute 59->0 carries to hour.
//   - hour 23->0 carries to day.
//   - day==max_date -> 1, carries to month.
//   - month 12->1 carries to year.
//   - year 4095 -> 1 (wrap).
//   - All carries resolve in one cycle; no intermediate values ever appear on the outputs.
//  max_date: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb per CONFIGURATION.
//  Widths: compares on 8-bit unsigned fields; year arithmetic is 12-bit with an explicit wrap test.
// CONFIGURATION
//  WATCH_LEAP_YEAR_EN defined:
//   - Feb max_date = 29 when (y%4==0 && y%100!=0) || y%400==0, else 28.
//   - The leap test is constant-divisor logic on year.
//  Undefined: Feb max_date is always 28; no leap logic is synthesised.
// STRUCTURE
//  Package watch_pkg:
//   - field widths (YEAR_W=12, FIELD_W=8), BIN_TIME_W=52
//   - bit-slice constants for bin_time
//   - function max_date(month,year), honouring WATCH_LEAP_YEAR_EN
//  Sub-module watch_sec_prescaler (CLK_FREQ; clk, rst, clr, hold -> tick).
//  Calendar counter and load sanitising stay in this module.
// TESTING (sim with CLK_FREQ=10)
//  1. rst=1 for 2 cycles -> outputs 2024-01-01 00:00:00, sec_pulse=0. First sec_pulse 10 cycles after rst drops.
//  2. Load 2023-12-31 23:59:59, wait 10 cycles -> 2024-01-01 00:00:00 in the same cycle as sec_pulse.
//  3. Load 2024-02-28 23:59:59, one tick -> 2024-02-29 00:00:00 with _EN defined; 2024-03-01 00:00:00 without.
//  4. Load month=13, day=31, hour=30, year=0 -> month=1, day=31, hour=0, year=1. Load 2023-04-31 -> day=30.
//  5. hold=1 for 25 cycles -> no sec_pulse, time unchanged. hold=0 -> next pulse after the remaining prescaler count.
//  6. en_time asserted on the tick cycle -> loaded value appears, no increment. Next pulse exactly 10 cycles later.
//     Also: rst mid-count -> reset values, prescaler restarts.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared widths, bin_time slice positions and the month-length helper for the watch calendar.
// February gets 29 days in leap years only when WATCH_LEAP_YEAR_EN is defined.
package watch_pkg;

  localparam int YEAR_W     = 12;
  localparam int FIELD_W    = 8;
  localparam int BIN_TIME_W = 52;

  localparam int YEAR_HI   = 51;
  localparam int YEAR_LO   = 40;
  localparam int MONTH_HI  = 39;
  localparam int MONTH_LO  = 32;
  localparam int DAY_HI    = 31;
  localparam int DAY_LO    = 24;
  localparam int HOUR_HI   = 23;
  localparam int HOUR_LO   = 16;
  localparam int MINUTE_HI = 15;
  localparam int MINUTE_LO = 8;
  localparam int SECOND_HI = 7;
  localparam int SECOND_LO = 0;

  function automatic logic [FIELD_W-1:0] max_date(input logic [FIELD_W-1:0] month,
                                                  input logic [YEAR_W-1:0]  year);
    logic                is_leap;
    logic [FIELD_W-1:0]  md;
`ifdef WATCH_LEAP_YEAR_EN
    is_leap = ((year % 12'd4) == 12'd0 && (year % 12'd100) != 12'd0) || (year % 12'd400) == 12'd0;
`else
    // Year only matters for the leap rule, which is compiled out here.
    is_leap = 1'b0 & year[0];
`endif
    case (month)
      8'd2:                    md = is_leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: md = 8'd30;
      default:                 md = 8'd31;
    endcase
    return md;
  endfunction

endpackage

// File: rtl/watch_time_counter_if.sv
// Set-block <-> calendar-core connection: load strobe, packed set time, hold, and the live time fields.
interface watch_time_counter_if;
  import watch_pkg::*;

  logic                  en_time;
  logic [BIN_TIME_W-1:0] bin_time;
  logic                  hold;
  logic [YEAR_W-1:0]     year;
  logic [FIELD_W-1:0]    month;
  logic [FIELD_W-1:0]    day;
  logic [FIELD_W-1:0]    hour;
  logic [FIELD_W-1:0]    minute;
  logic [FIELD_W-1:0]    second;
  logic                  sec_pulse;

  modport master (
    output en_time, bin_time, hold,
    input  year, month, day, hour, minute, second, sec_pulse
  );

  modport slave (
    input  en_time, bin_time, hold,
    output year, month, day, hour, minute, second, sec_pulse
  );

endinterface

// File: rtl/watch_sec_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_FREQ cycles; tick is combinational off the count.
// clr restarts the count at 0, hold freezes it and suppresses tick.
module watch_sec_prescaler #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int              CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !hold && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Calendar/clock core: loads a sanitised set time, advances one second per prescaler tick with full carry.
// Outputs are registered (1-cycle load latency); hold freezes everything but a load. Leap years: WATCH_LEAP_YEAR_EN.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int                CLK_FREQ   = 50_000_000,
  parameter logic [YEAR_W-1:0] RESET_YEAR = 12'd2024
) (
  input  logic                 clk,
  input  logic                 rst,
  watch_time_counter_if.slave  tif
);

  localparam logic [YEAR_W-1:0] YEAR_MAX = {YEAR_W{1'b1}};

  logic                tick;
  logic [YEAR_W-1:0]   year_q;
  logic [FIELD_W-1:0]  month_q, day_q, hour_q, minute_q, second_q;
  logic                pulse_q;

  watch_sec_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (tif.en_time),
    .hold (tif.hold),
    .tick (tick)
  );

  // Load path: clamp every field into a legal calendar value before it reaches the registers.
  logic [YEAR_W-1:0]  ld_year, s_year;
  logic [FIELD_W-1:0] ld_month, ld_day, ld_hour, ld_minute, ld_second;
  logic [FIELD_W-1:0] s_month, s_day, s_hour, s_minute, s_second, ld_md;

  assign ld_year   = tif.bin_time[YEAR_HI:YEAR_LO];
  assign ld_month  = tif.bin_time[MONTH_HI:MONTH_LO];
  assign ld_day    = tif.bin_time[DAY_HI:DAY_LO];
  assign ld_hour   = tif.bin_time[HOUR_HI:HOUR_LO];
  assign ld_minute = tif.bin_time[MINUTE_HI:MINUTE_LO];
  assign ld_second = tif.bin_time[SECOND_HI:SECOND_LO];

  always_comb begin
    s_year   = (ld_year == '0) ? 12'd1 : ld_year;
    s_month  = (ld_month == 8'd0 || ld_month > 8'd12) ? 8'd1 : ld_month;
    ld_md    = max_date(s_month, s_year);
    s_day    = (ld_day == 8'd0) ? 8'd1 : ((ld_day > ld_md) ? ld_md : ld_day);
    s_hour   = (ld_hour   > 8'd23) ? 8'd0 : ld_hour;
    s_minute = (ld_minute > 8'd59) ? 8'd0 : ld_minute;
    s_second = (ld_second > 8'd59) ? 8'd0 : ld_second;
  end

  // Advance path: the whole carry chain settles combinationally so outputs jump straight to the next second.
  logic               sec_wrap, min_wrap, hr_wrap, day_wrap, mon_wrap;
  logic [FIELD_W-1:0] cur_md;
  logic [YEAR_W-1:0]  nx_year;
  logic [FIELD_W-1:0] nx_month, nx_day, nx_hour, nx_minute, nx_second;

  always_comb begin
    cur_md    = max_date(month_q, year_q);
    sec_wrap  = (second_q == 8'd59);
    min_wrap  = sec_wrap && (minute_q == 8'd59);
    hr_wrap   = min_wrap && (hour_q == 8'd23);
    day_wrap  = hr_wrap && (day_q >= cur_md);
    mon_wrap  = day_wrap && (month_q == 8'd12);

    nx_second = sec_wrap ? 8'd0 : second_q + 8'd1;
    nx_minute = minute_q;
    nx_hour   = hour_q;
    nx_day    = day_q;
    nx_month  = month_q;
    nx_year   = year_q;
    if (sec_wrap) nx_minute = min_wrap ? 8'd0 : minute_q + 8'd1;
    if (min_wrap) nx_hour   = hr_wrap  ? 8'd0 : hour_q + 8'd1;
    if (hr_wrap)  nx_day    = day_wrap ? 8'd1 : day_q + 8'd1;
    if (day_wrap) nx_month  = mon_wrap ? 8'd1 : month_q + 8'd1;
    if (mon_wrap) nx_year   = (year_q == YEAR_MAX) ? 12'd1 : year_q + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      year_q   <= RESET_YEAR;
      month_q  <= 8'd1;
      day_q    <= 8'd1;
      hour_q   <= 8'd0;
      minute_q <= 8'd0;
      second_q <= 8'd0;
      pulse_q  <= 1'b0;
    end else if (tif.en_time) begin
      year_q   <= s_year;
      month_q  <= s_month;
      day_q    <= s_day;
      hour_q   <= s_hour;
      minute_q <= s_minute;
      second_q <= s_second;
      pulse_q  <= 1'b0;
    end else if (tif.hold) begin
      pulse_q  <= 1'b0;
    end else if (tick) begin
      year_q   <= nx_year;
      month_q  <= nx_month;
      day_q    <= nx_day;
      hour_q   <= nx_hour;
      minute_q <= nx_minute;
      second_q <= nx_second;
      pulse_q  <= 1'b1;
    end else begin
      pulse_q  <= 1'b0;
    end
  end

  assign tif.year      = year_q;
  assign tif.month     = month_q;
  assign tif.day       = day_q;
  assign tif.hour      = hour_q;
  assign tif.minute    = minute_q;
  assign tif.second    = second_q;
  assign tif.sec_pulse = pulse_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed plus random stimulus for watch_time_counter (CLK_FREQ=10) against a seconds-of-day calendar model.
module tb_watch_time_counter;

  localparam int CF = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  watch_time_counter_if tif();

  watch_time_counter #(
    .CLK_FREQ   (CF),
    .RESET_YEAR (12'd2024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  always #5 clk = ~clk;

  // Reference state: calendar fields, cycles since the last restart of the second, last pulse.
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_cnt;
  bit m_p;

  function automatic int dim(input int mo, input int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int r;
    r = t[mo-1];
`ifdef WATCH_LEAP_YEAR_EN
    if (mo == 2 && ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0)) r = 29;
`endif
    return r;
  endfunction

  function automatic logic [60:0] pk(input int y, input int mo, input int d, input int h,
                                     input int mi, input int s, input bit p);
    return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), p};
  endfunction

  function automatic logic [51:0] mkbt(input int y, input int mo, input int d, input int h,
                                       input int mi, input int s);
    return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  function automatic logic [60:0] dut_vec();
    return {tif.year, tif.month, tif.day, tif.hour, tif.minute, tif.second, tif.sec_pulse};
  endfunction

  task automatic chk(input string tag, input logic [60:0] obs, input logic [60:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [51:0] bt);
    m_y  = int'(bt[51:40]);
    m_mo = int'(bt[39:32]);
    m_d  = int'(bt[31:24]);
    m_h  = int'(bt[23:16]);
    m_mi = int'(bt[15:8]);
    m_s  = int'(bt[7:0]);
    if (m_y == 0) m_y = 1;
    if (m_mo == 0 || m_mo > 12) m_mo = 1;
    if (m_d == 0) m_d = 1;
    else if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
    if (m_h > 23) m_h = 0;
    if (m_mi > 59) m_mi = 0;
    if (m_s > 59) m_s = 0;
  endtask

  task automatic model_advance();
    int sod;
    sod = m_h * 3600 + m_mi * 60 + m_s + 1;
    if (sod == 86400) begin
      sod = 0;
      m_d++;
      if (m_d > dim(m_mo, m_y)) begin
        m_d = 1;
        m_mo++;
        if (m_mo > 12) begin
          m_mo = 1;
          m_y  = (m_y == 4095) ? 1 : m_y + 1;
        end
      end
    end
    m_h  = sod / 3600;
    m_mi = (sod % 3600) / 60;
    m_s  = sod % 60;
  endtask

  // One clock: drive inputs, step the model at the edge, compare everything 1 time unit later.
  task automatic cycle(input bit r, input bit en, input bit hd, input logic [51:0] bt, input string tag);
    rst          = r;
    tif.en_time  = en;
    tif.hold     = hd;
    tif.bin_time = bt;
    @(posedge clk);
    m_p = 1'b0;
    if (r) begin
      m_y = 2024; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_cnt = 0;
    end else if (en) begin
      model_load(bt);
      m_cnt = 0;
    end else if (!hd) begin
      if (m_cnt == CF - 1) begin
        model_advance();
        m_cnt = 0;
        m_p   = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    #1;
    chk(tag, dut_vec(), pk(m_y, m_mo, m_d, m_h, m_mi, m_s, m_p));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 52'd0, tag);
  endtask

  task automatic load(input logic [51:0] bt, input string tag);
    cycle(1'b0, 1'b1, 1'b0, bt, tag);
  endtask

  initial begin
    int guard;
    bit hd;
    logic [51:0] bt;
    m_y = 0; m_mo = 0; m_d = 0; m_h = 0; m_mi = 0; m_s = 0; m_cnt = 0; m_p = 1'b0;
    tif.en_time = 1'b0;
    tif.hold    = 1'b0;
    tif.bin_time = '0;

    cycle(1'b1, 1'b0, 1'b0, 52'd0, "reset");
    cycle(1'b1, 1'b1, 1'b1, mkbt(1999, 5, 5, 5, 5, 5), "reset_over_load");
    chk("reset_const", dut_vec(), pk(2024, 1, 1, 0, 0, 0, 0));
    idle(10, "first_second");
    chk("first_pulse_const", dut_vec(), pk(2024, 1, 1, 0, 0, 1, 1));

    load(mkbt(2023, 12, 31, 23, 59, 59), "load_nye");
    idle(10, "nye_run");
    chk("year_rollover", dut_vec(), pk(2024, 1, 1, 0, 0, 0, 1));

    load(mkbt(2024, 2, 28, 23, 59, 59), "load_feb28");
    idle(10, "feb_run");
`ifdef WATCH_LEAP_YEAR_EN
    chk("feb_leap", dut_vec(), pk(2024, 2, 29, 0, 0, 0, 1));
`else
    chk("feb_noleap", dut_vec(), pk(2024, 3, 1, 0, 0, 0, 1));
`endif

    load(mkbt(0, 13, 31, 30, 0, 0), "load_bad");
    chk("sanitise_fields", dut_vec(), pk(1, 1, 31, 0, 0, 0, 0));
    load(mkbt(2023, 4, 31, 12, 61, 75), "load_apr31");
    chk("sanitise_apr31", dut_vec(), pk(2023, 4, 30, 12, 0, 0, 0));
    load(mkbt(4095, 12, 31, 23, 59, 59), "load_ymax");
    idle(10, "ymax_run");
    chk("year_wrap", dut_vec(), pk(1, 1, 1, 0, 0, 0, 1));

    load(mkbt(2024, 6, 15, 10, 20, 30), "load_hold");
    idle(3, "pre_hold");
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'b1, 52'd0, "hold");
    chk("hold_frozen", dut_vec(), pk(2024, 6, 15, 10, 20, 30, 0));
    idle(7, "post_hold");
    chk("hold_resume", dut_vec(), pk(2024, 6, 15, 10, 20, 31, 1));

    guard = 0;
    while (m_cnt != CF - 1 && guard < 2 * CF) begin
      idle(1, "to_tick");
      guard++;
    end
    chk("tick_reached", {60'd0, (m_cnt == CF - 1)}, 61'd1);
    load(mkbt(2030, 7, 4, 8, 0, 0), "load_on_tick");
    chk("load_on_tick_const", dut_vec(), pk(2030, 7, 4, 8, 0, 0, 0));
    idle(9, "after_tick_load");
    idle(1, "after_tick_load");
    chk("tick_load_next", dut_vec(), pk(2030, 7, 4, 8, 0, 1, 1));

    idle(4, "mid_count");
    cycle(1'b1, 1'b0, 1'b0, 52'd0, "mid_reset");
    chk("mid_reset_const", dut_vec(), pk(2024, 1, 1, 0, 0, 0, 0));
    idle(10, "post_reset");
    chk("post_reset_pulse", dut_vec(), pk(2024, 1, 1, 0, 0, 1, 1));

    hd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) hd = !hd;
      if ($urandom_range(0, 1) == 0)
        bt = mkbt($urandom_range(0, 4095), $urandom_range(0, 14), $urandom_range(0, 33),
                  $urandom_range(20, 25), $urandom_range(57, 61), $urandom_range(50, 61));
      else
        bt = mkbt($urandom_range(1, 4095), $urandom_range(1, 12), $urandom_range(1, 28),
                  $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      cycle($urandom_range(0, 699) == 0, $urandom_range(0, 39) == 0, hd, bt, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
